// File: rtl/systolic_mac_array_if.sv
// Bundle of the operand stream and result signals for systolic_mac_array.
//   master : drives iClear / iValid / iRow / iCol, receives oResult / oDone
//   slave  : the array; receives the streams, drives the result matrix
// iRow[i] feeds PE(i,0); iCol[j] feeds PE(0,j); oResult[i][j] is C[i][j].
interface systolic_mac_array_if #(
    parameter int BW    = 8,
    parameter int N     = 5,
    parameter int ACC_W = 2 * BW + $clog2(N)
);
    logic                            iClear;
    logic                            iValid;
    logic [N-1:0][BW-1:0]            iRow;
    logic [N-1:0][BW-1:0]            iCol;
    logic [N-1:0][N-1:0][ACC_W-1:0]  oResult;
    logic                            oDone;

    modport master (output iClear, iValid, iRow, iCol, input oResult, oDone);
    modport slave  (input iClear, iValid, iRow, iCol, output oResult, oDone);
endinterface

// File: rtl/systolic_mac_array.sv
// Output-stationary NxN systolic MAC array computing C = A*B from skewed
// row (A, left to right) and column (B, top to bottom) streams.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    systolic_mac_array_if.slave: iClear, iValid, iRow, iCol in;
//          oResult (per-PE accumulators), oDone out
// Optional build macro: SYSTOLIC_SATURATE_EN -- accumulators clamp at
// 2^ACC_W-1 instead of wrapping.

// One processing element: forwards its operands and accumulates a*b.
module systolic_mac_pe #(
    parameter int BW    = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iClear,
    input  logic             iStep,
    input  logic [BW-1:0]    iA,
    input  logic [BW-1:0]    iB,
    output logic [BW-1:0]    oA,
    output logic [BW-1:0]    oB,
    output logic [ACC_W-1:0] oAcc
);
    localparam int PW = 2 * BW;
    // Sum is wide enough to see a carry out of the accumulator even when
    // ACC_W is narrower than the product.
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

    logic [PW-1:0]    prod;
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] accNext;

    assign prod = PW'(iA) * PW'(iB);
    assign sum  = SW'(oAcc) + SW'(prod);

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    // Once clamped, acc + any product stays at or above max, so it sticks.
    assign accNext = (sum > SW'(ACC_MAX)) ? ACC_MAX : sum[ACC_W-1:0];
`else
    logic unusedCarry;
    assign unusedCarry = ^sum[SW-1:ACC_W];
    assign accNext     = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oA   <= '0;
            oB   <= '0;
            oAcc <= '0;
        end else if (iClear) begin
            oA   <= '0;
            oB   <= '0;
            oAcc <= '0;
        end else if (iStep) begin
            oA   <= iA;
            oB   <= iB;
            oAcc <= accNext;
        end
    end
endmodule

module systolic_mac_array #(
    parameter int BW    = 8,
    parameter int N     = 5,
    parameter int ACC_W = 2 * BW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_mac_array_if.slave  bus
);
    localparam int LAST = 3 * N - 3;       // beat of the final product
    localparam int CW   = $clog2(3 * N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, nextState;
    logic [CW-1:0] cnt, cntNext;
    logic          step;
    logic          edgeEn;

    logic [N-1:0][BW-1:0]           rowG, colG;
    logic [N-1:0][N-1:0][BW-1:0]    aIn, bIn, aOut, bOut;
    logic [N-1:0][N-1:0][ACC_W-1:0] accW;
    logic [N-1:0]                   unusedA, unusedB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        nextState = state;
        cntNext   = cnt;
        step      = 1'b0;
        if (bus.iClear) begin
            nextState = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: if (bus.iValid) begin
                    // This cycle is beat 0 and is accumulated.
                    step      = 1'b1;
                    cntNext   = CW'(1);
                    nextState = (LAST == 0) ? DONE : RUN;
                end
                RUN: begin
                    // Counter advances regardless of iValid; gaps inject zeros.
                    step    = 1'b1;
                    cntNext = cnt + CW'(1);
                    if (cnt == CW'(LAST)) nextState = DONE;
                end
                DONE:    ;
                default: nextState = IDLE;
            endcase
        end
    end

    // Edge operands are only real while a beat can be taken.
    assign edgeEn = bus.iValid && (state != DONE);

    genvar i, j;
    generate
        for (i = 0; i < N; i++) begin : genEdge
            assign rowG[i]    = edgeEn ? bus.iRow[i] : '0;
            assign colG[i]    = edgeEn ? bus.iCol[i] : '0;
            assign unusedA[i] = ^aOut[i][N-1];
            assign unusedB[i] = ^bOut[N-1][i];
        end
        for (i = 0; i < N; i++) begin : genRow
            for (j = 0; j < N; j++) begin : genCol
                if (j == 0) begin : genAEdge
                    assign aIn[i][j] = rowG[i];
                end else begin : genAChain
                    assign aIn[i][j] = aOut[i][j-1];
                end
                if (i == 0) begin : genBEdge
                    assign bIn[i][j] = colG[j];
                end else begin : genBChain
                    assign bIn[i][j] = bOut[i-1][j];
                end
                systolic_mac_pe #(.BW(BW), .ACC_W(ACC_W)) uPe (
                    .clk    (clk),
                    .rst_n  (rst_n),
                    .iClear (bus.iClear),
                    .iStep  (step),
                    .iA     (aIn[i][j]),
                    .iB     (bIn[i][j]),
                    .oA     (aOut[i][j]),
                    .oB     (bOut[i][j]),
                    .oAcc   (accW[i][j])
                );
            end
        end
    endgenerate

    assign bus.oResult = accW;
    assign bus.oDone   = (state == DONE);
endmodule

// File: tb/tb_systolic_mac_array.sv
module tb_systolic_mac_array;
    localparam int BW    = 8;
    localparam int N     = 5;
    localparam int ACC_W = 19;
    localparam int LAST  = 3 * N - 3;

    typedef int mat_t [N][N];
    typedef logic [N-1:0][N-1:0][ACC_W-1:0] res_t;
    typedef logic [N-1:0][N-1:0][15:0]      res16_t;
    typedef struct {
        res_t res;
        int   doneEdge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_mac_array_if #(.BW(BW), .N(N), .ACC_W(ACC_W)) bus ();
    systolic_mac_array_if #(.BW(BW), .N(N), .ACC_W(16))    bus16 ();

    systolic_mac_array #(.BW(BW), .N(N), .ACC_W(ACC_W)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus));
    systolic_mac_array #(.BW(BW), .N(N), .ACC_W(16)) dut16 (
        .clk (clk), .rst_n (rst_n), .bus (bus16));

    assign bus16.iClear = bus.iClear;
    assign bus16.iValid = bus.iValid;
    assign bus16.iRow   = bus.iRow;
    assign bus16.iCol   = bus.iCol;

    int   nCompared = 0;
    int   nFail = 0;
    int   edgeCnt = 0;
    exp_t q[$];
    res_t curExp = '0;
    bit   prevDone = 1'b0;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkMat(input string name, input res_t act, input res_t exp);
        nCompared++;
        if (act != exp) begin
            nFail++;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (act[i][j] != exp[i][j]) begin
                        $display("FAIL %s: C[%0d][%0d] got %0d expected %0d",
                                 name, i, j, act[i][j], exp[i][j]);
                        return;
                    end
        end
    endtask

    // Monitor: on oDone rising pop the expected matrix and latency; while
    // oDone stays high the result must hold at that matrix.
    always @(negedge clk) begin
        if (bus.oDone && !prevDone) begin
            if (q.size() == 0) begin
                chk("unexpectedDone", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("doneEdge", edgeCnt, e.doneEdge);
                chkMat("result", bus.oResult, e.res);
                curExp = e.res;
            end
        end else if (bus.oDone) begin
            chkMat("holdResult", bus.oResult, curExp);
        end
        prevDone = bus.oDone;
    end

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic driveBeat(input mat_t a, input mat_t b, input int t, input bit v);
        bus.iValid = v;
        for (int i = 0; i < N; i++) begin
            int k;
            k = t - i;
            bus.iRow[i] = '0;
            bus.iCol[i] = '0;
            if (k >= 0 && k < N) begin
                bus.iRow[i] = BW'(a[i][k]);
                bus.iCol[i] = BW'(b[k][i]);
            end
        end
    endtask

    task automatic idleInputs();
        bus.iValid = 1'b0;
        bus.iRow   = '0;
        bus.iCol   = '0;
    endtask

    task automatic waitDone();
        for (int c = 0; c < 40 && !bus.oDone; c++) stepEdge();
        chk("doneTimeout", bus.oDone, 1);
    endtask

    task automatic runMatrix(input mat_t a, input mat_t b, input int gap, input res_t exp);
        exp_t e;
        e.res      = exp;
        e.doneEdge = edgeCnt + 1 + LAST;
        q.push_back(e);
        for (int t = 0; t < 2 * N - 1; t++) begin
            driveBeat(a, b, t, t != gap);
            stepEdge();
        end
        idleInputs();
        waitDone();
    endtask

    task automatic doClear();
        bus.iClear = 1'b1;
        stepEdge();
        bus.iClear = 1'b0;
        chk("clearDone", bus.oDone, 0);
        chkMat("clearResult", bus.oResult, '0);
    endtask

    mat_t aId, bPat, aFull;
    res_t expPat, expFull, expId, expGap;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int n;
                aId[i][j]     = (i == j) ? 1 : 0;
                bPat[i][j]    = 5 * i + j + 1;
                aFull[i][j]   = 255;
                expPat[i][j]  = ACC_W'(5 * i + j + 1);
                expFull[i][j] = ACC_W'(325125);
                expId[i][j]   = ACC_W'((i == j) ? 1 : 0);
                // Beat 3 dropped: row term zero when i+k==3, column when j+k==3.
                n = 0;
                for (int k = 0; k < N; k++)
                    if (i + k != 3 && j + k != 3) n++;
                expGap[i][j]  = ACC_W'(n * 65025);
            end

        bus.iClear = 1'b0;
        idleInputs();
        repeat (3) stepEdge();
        rst_n = 1'b1;
        stepEdge();
        chk("resetDone", bus.oDone, 0);
        chkMat("resetResult", bus.oResult, '0);

        // Identity x pattern.
        runMatrix(aId, bPat, -1, expPat);
        doClear();

        // All 255: main array fits, 16-bit copy wraps or clamps.
        runMatrix(aFull, aFull, -1, expFull);
        chk("done16", bus16.oDone, 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
`ifdef SYSTOLIC_SATURATE_EN
                chk("result16", bus16.oResult[i][j], 65535);
`else
                chk("result16", bus16.oResult[i][j], 62981);
`endif

        // Nonzero valid data in DONE is ignored.
        for (int c = 0; c < 5; c++) begin
            bus.iValid = 1'b1;
            bus.iRow   = {N{8'hAA}};
            bus.iCol   = {N{8'h55}};
            stepEdge();
            chk("doneHeld", bus.oDone, 1);
        end
        idleInputs();
        doClear();
        runMatrix(aId, aId, -1, expId);
        doClear();

        // Reset at beat 4 aborts the run.
        for (int t = 0; t < 4; t++) begin
            driveBeat(aFull, aFull, t, 1'b1);
            stepEdge();
        end
        driveBeat(aFull, aFull, 4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abortDone", bus.oDone, 0);
        chkMat("abortResult", bus.oResult, '0);
        idleInputs();
        stepEdge();
        stepEdge();
        rst_n = 1'b1;
        stepEdge();
        chkMat("postResetResult", bus.oResult, '0);
        runMatrix(aId, bPat, -1, expPat);
        doClear();

        // Valid gap on beat 3 with live data.
        runMatrix(aFull, aFull, 3, expGap);
        doClear();

        repeat (2) stepEdge();
        chk("pendingExpected", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end
endmodule
